// File: rtl/fetch_unit_pkg.sv
// Shared widths, fetch step and the fetch-buffer entry type for the fetch unit.
package fetch_unit_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Fetch FIFO of DEPTH {pc, instr} entries; head is a register read, 1-cycle push-to-head.
// Push is refused when full unless a pop happens in the same cycle; flush empties it at once.
module fetch_buffer
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  // DEPTH is a power of two, so the pointers wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (!do_push && do_pop) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, redirect/stall control and a fetch buffer; head valid 1 cycle after fetch,
// fetch stops when the buffer is full and not draining. FETCH_MISALIGN_CHECK_EN adds misalign_err.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] instruction_address,
  input  logic [31:0] instruction,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        misalign_err
`endif
);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] fetch_pc_nxt;
  logic            buf_full;
  logic            buf_empty;
  logic            pop;
  logic            fetch;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  assign if_valid = !buf_empty;
  assign if_pc    = head.pc;
  assign if_instr = head.instr;
  assign pop      = if_valid && if_ready;

  // A full buffer can still accept the new word when the head leaves in the same cycle.
  assign fetch    = !stall && !redirect_valid && (!buf_full || pop);

  assign instruction_address = {2'b00, fetch_pc[XLEN-1:2]};
  assign push_entry.pc       = fetch_pc;
  assign push_entry.instr    = instruction;

  always_comb begin
    fetch_pc_nxt = fetch_pc;
    if (redirect_valid) begin
      fetch_pc_nxt = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (fetch) begin
      fetch_pc_nxt = fetch_pc + PC_STEP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
    end else begin
      fetch_pc <= fetch_pc_nxt;
    end
  end

  fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_fetch_buffer (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_valid),
    .push       (fetch),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (buf_full),
    .empty      (buf_empty)
  );

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
    end
  end
`else
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized bench for fetch_unit against a queue-based reference model.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk;
  logic        rst_n;
  logic [31:0] instruction_address;
  logic [31:0] instruction;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misalign_err;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: pending fetched PCs in order, next PC to fetch, expected misalign flag.
  logic [31:0] m_q[$];
  logic [31:0] m_pc;
  logic        m_mis;

  fetch_unit #(
    .RESET_PC  (RESET_PC),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .instruction_address (instruction_address),
    .instruction         (instruction),
    .if_valid            (if_valid),
    .if_ready            (if_ready),
    .if_instr            (if_instr),
    .if_pc               (if_pc),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .stall               (stall)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .misalign_err        (misalign_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: word i holds 32'h1000_0000 + i.
  assign instruction = 32'h1000_0000 + instruction_address;

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return 32'h1000_0000 + {2'b00, pc[31:2]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc  = RESET_PC;
    m_mis = 1'b0;
  endtask

  task automatic check_outputs();
    chk("if_valid", {31'd0, if_valid}, {31'd0, m_q.size() != 0});
    if (m_q.size() != 0) begin
      chk("if_pc", if_pc, m_q[0]);
      chk("if_instr", if_instr, mem_word(m_q[0]));
    end
    chk("instruction_address", instruction_address, {2'b00, m_pc[31:2]});
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
`endif
  endtask

  // One clock: check current outputs, apply inputs, advance model, move to the next falling edge.
  task automatic step(input bit rdy, input bit stl, input bit rv, input logic [31:0] rpc);
    bit pop_m;
    bit full_m;
    check_outputs();
    if_ready       = rdy;
    stall          = stl;
    redirect_valid = rv;
    redirect_pc    = rpc;
    pop_m  = (m_q.size() != 0) && rdy;
    full_m = (m_q.size() == DEPTH);
    m_mis  = rv && (rpc[1:0] != 2'b00);
    if (rv) begin
      m_q.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      if (pop_m) void'(m_q.pop_front());
      if (!stl && (!full_m || pop_m)) begin
        m_q.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n          = 1'b0;
    if_ready       = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_addr", instruction_address, {2'b00, RESET_PC[31:2]});
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
`endif
    rst_n = 1'b1;

    // Reset/stream
    step(1, 0, 0, 32'h0);
    chk("stream_first_valid", {31'd0, if_valid}, 32'd1);
    chk("stream_first_pc", if_pc, 32'h0);
    chk("stream_first_instr", if_instr, 32'h1000_0000);
    repeat (6) step(1, 0, 0, 32'h0);

    // Backpressure then release
    repeat (5) step(0, 0, 0, 32'h0);
    chk("bp_valid_held", {31'd0, if_valid}, 32'd1);
    repeat (6) step(1, 0, 0, 32'h0);

    // Redirect with a full buffer
    repeat (3) step(0, 0, 0, 32'h0);
    step(0, 0, 1, 32'h40);
    chk("redir_valid_drop", {31'd0, if_valid}, 32'd0);
    step(1, 0, 0, 32'h0);
    chk("redir_pc", if_pc, 32'h40);
    chk("redir_instr", if_instr, 32'h1000_0010);
    repeat (2) step(1, 0, 0, 32'h0);

    // Stall with two buffered entries: drain, then hold
    repeat (3) step(0, 0, 0, 32'h0);
    repeat (3) step(1, 1, 0, 32'h0);
    chk("stall_drained", {31'd0, if_valid}, 32'd0);
    repeat (2) step(1, 1, 0, 32'h0);
    repeat (3) step(1, 0, 0, 32'h0);

    // PC wrap
    step(1, 0, 1, 32'hFFFF_FFFC);
    step(1, 0, 0, 32'h0);
    chk("wrap_last_pc", if_pc, 32'hFFFF_FFFC);
    step(1, 0, 0, 32'h0);
    chk("wrap_pc", if_pc, 32'h0);
    chk("wrap_instr", if_instr, 32'h1000_0000);
    repeat (2) step(1, 0, 0, 32'h0);

`ifdef FETCH_MISALIGN_CHECK_EN
    // Misaligned redirect
    step(1, 0, 1, 32'h0000_0046);
    chk("mis_pulse", {31'd0, misalign_err}, 32'd1);
    step(1, 0, 0, 32'h0);
    chk("mis_clear", {31'd0, misalign_err}, 32'd0);
    chk("mis_pc", if_pc, 32'h44);
    repeat (2) step(1, 0, 0, 32'h0);
`endif

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] rpc;
      rpc = $urandom;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 19) == 0, rpc);
    end

    // Reset asserted mid-stream
    repeat (3) step(1, 0, 0, 32'h0);
    chk("mid_pre_valid", {31'd0, if_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, if_valid}, 32'd0);
    chk("mid_rst_pc", if_pc, 32'h0);
    chk("mid_rst_instr", if_instr, 32'h0);
    chk("mid_rst_addr", instruction_address, {2'b00, RESET_PC[31:2]});
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) step(1, 0, 0, 32'h0);
    check_outputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
